// File: rtl/mem_pkg.sv
// Shared types and constants for the mem_responder memory slice.
package mem_pkg;

  localparam int WORD_W = 32;
  localparam int DEPTH_WORDS_DEFAULT = 64;

  // Word-index width for a memory of the given depth (depth is a power of two).
  function automatic int idx_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  localparam int IDX_W_DEFAULT = idx_width(DEPTH_WORDS_DEFAULT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_array.sv
// Single-port word RAM: synchronous write, registered read-before-write.
// No reset on the storage so it maps onto block RAM.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Write port and registered read of the same address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/mem_responder.sv
// Unified instruction/data memory, responder side of a valid/ready
// request/response port with WAIT_CYCLES wait states per access.
// Optional feature macro: MEMRESP_ERR_EN (misaligned / out-of-range faults).
// Without it, addr[1:0] and upper address bits are ignored and rsp_err is 0.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = idx_width(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic              write_reg;
  logic [WORD_W-1:0] addr_reg, wdata_reg;
  logic              err_reg;
  logic              fresh_reg;   // rsp_rdata comes straight from the RAM output
  logic [WORD_W-1:0] hold_reg;    // rsp_rdata once the RAM output is no longer valid
  logic              accept;
  logic              enter_resp;

  // The operation is executed on the edge that enters RESP. With zero wait
  // states that edge is the acceptance edge, so the live request is used.
  logic              op_write;
  logic [WORD_W-1:0] op_addr, op_wdata;
  logic              op_err;
  logic              ram_we;
  logic [IDX_W-1:0]  ram_idx;
  logic [WORD_W-1:0] ram_rdata;

  assign op_write = (state_reg == IDLE) ? req_write : write_reg;
  assign op_addr  = (state_reg == IDLE) ? req_addr  : addr_reg;
  assign op_wdata = (state_reg == IDLE) ? req_wdata : wdata_reg;

`ifdef MEMRESP_ERR_EN
  localparam logic [WORD_W-1:0] ADDR_LIMIT = WORD_W'(4 * DEPTH_WORDS);
  assign op_err = (op_addr[1:0] != 2'b00) || (op_addr >= ADDR_LIMIT);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{op_addr[WORD_W-1:IDX_W+2], op_addr[1:0]};
  assign op_err = 1'b0;
`endif

  assign ram_idx = op_addr[IDX_W+1:2];
  // A reset on the committing edge abandons the write.
  assign ram_we  = enter_resp && op_write && !op_err && !reset;

  mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk  (clk),
    .we   (ram_we),
    .idx  (ram_idx),
    .wdata(op_wdata),
    .rdata(ram_rdata)
  );

  // Next-state, wait counter and handshake outputs. BUSY lasts WAIT_CYCLES
  // cycles: the edge that brings the counter down to zero enters RESP.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = !reset;
        if (req_valid && !reset) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = BUSY;
            cnt_next   = WAIT_LOAD;
          end
        end
      end
      BUSY: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg <= 4'd1) begin
          state_next = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, counter, request latch and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      write_reg <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      err_reg   <= 1'b0;
      fresh_reg <= 1'b0;
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        write_reg <= req_write;
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
      end
      if (enter_resp) begin
        err_reg   <= op_err;
        fresh_reg <= !op_write && !op_err;
        hold_reg  <= '0;
      end else if (state_reg == RESP && rsp_ready && fresh_reg) begin
        // Capture read data before the RAM address moves on.
        hold_reg  <= ram_rdata;
        fresh_reg <= 1'b0;
      end
    end
  end

  assign rsp_rdata = fresh_reg ? ram_rdata : hold_reg;
  assign rsp_err   = err_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance with 2 wait states,
// one with 0 wait states. Stimulus pushes expected responses; monitors
// pop and compare when the DUT presents rsp_valid.
module tb_mem_responder;

`ifdef MEMRESP_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_acc [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  function automatic int wait_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic cmp_rsp(input int d, input exp_t e, input bit first);
    if (first) check($sformatf("latency d%0d a=%h", d, e.addr), cyc, e.cyc);
    check($sformatf("rdata d%0d a=%h", d, e.addr), rsp_rdata[d], e.rdata);
    check($sformatf("err d%0d a=%h", d, e.addr), {31'd0, rsp_err[d]}, {31'd0, e.err});
  endtask

  // Monitor for the 2-wait-state instance.
  initial begin
    bit first = 1'b1;
    forever begin
      @(negedge clk);
      if (rsp_valid[0] === 1'b1) begin
        if (q0.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rsp d0: got rdata %h want no response", rsp_rdata[0]);
        end else begin
          cmp_rsp(0, q0[0], first);
          first = 1'b0;
          if (rsp_ready[0] === 1'b1) begin
            $display("rsp d0 addr=%h rdata=%h err=%0d cyc=%0d", q0[0].addr, rsp_rdata[0], rsp_err[0], cyc);
            void'(q0.pop_front());
            first = 1'b1;
          end
        end
      end
    end
  end

  // Monitor for the 0-wait-state instance.
  initial begin
    bit first = 1'b1;
    forever begin
      @(negedge clk);
      if (rsp_valid[1] === 1'b1) begin
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rsp d1: got rdata %h want no response", rsp_rdata[1]);
        end else begin
          cmp_rsp(1, q1[0], first);
          first = 1'b0;
          if (rsp_ready[1] === 1'b1) begin
            $display("rsp d1 addr=%h rdata=%h err=%0d cyc=%0d", q1[0].addr, rsp_rdata[1], rsp_err[1], cyc);
            void'(q1.pop_front());
            first = 1'b1;
          end
        end
      end
    end
  end

  // Issue one request (called #1 after a rising edge); returns #1 after acceptance.
  task automatic issue(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input bit push);
    int n = 0;
    exp_t e;
    while (req_ready[d] !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (req_ready[d] !== 1'b1) begin
      total++; bad++;
      $display("FAIL ready_timeout d%0d: got req_ready %b want 1", d, req_ready[d]);
      return;
    end
    req_valid[d] = 1'b1;
    req_write[d] = w;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    req_write[d] = ~w;
    req_addr[d]  = 32'hFFFF_FFFC;
    req_wdata[d] = 32'h5A5A_5A5A;
    last_acc[d]  = cyc;
    if (push) begin
      e.addr = a; e.rdata = er; e.err = ee; e.cyc = cyc + wait_of(d);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic drain(input int d);
    int n = 0;
    while (qsize(d) != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (qsize(d) != 0) begin
      total++; bad++;
      $display("FAIL rsp_timeout d%0d: got %0d pending want 0", d, qsize(d));
      if (d == 0) q0.delete();
      else        q1.delete();
    end
  endtask

  task automatic xact(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] er, input logic ee);
    issue(d, w, a, wd, er, ee, 1'b1);
    drain(d);
  endtask

  initial begin
    int a0;
    int n;
    logic [31:0] v10;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0;
      req_addr[d] = '0; req_wdata[d] = '0; rsp_ready[d] = 1'b1;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    // Reset values while reset is high.
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_req_ready d%0d", d), {31'd0, req_ready[d]}, 32'd0);
      check($sformatf("rst_rsp_valid d%0d", d), {31'd0, rsp_valid[d]}, 32'd0);
      check($sformatf("rst_rdata d%0d", d), rsp_rdata[d], 32'd0);
      check($sformatf("rst_err d%0d", d), {31'd0, rsp_err[d]}, 32'd0);
    end
    reset = 1'b0;
    #1;
    check("post_rst_req_ready d0", {31'd0, req_ready[0]}, 32'd1);
    @(posedge clk); #1;

    // Two wait states: write/read, out-of-range and misaligned.
    xact(0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0, 1'b0);
    xact(0, 1'b0, 32'h10,  32'h0, 32'hDEADBEEF, 1'b0);
    xact(0, 1'b1, 32'h4,   32'h11111111, 32'h0, 1'b0);
    xact(0, 1'b1, 32'h104, 32'hCAFEF00D, 32'h0, ERR);
    xact(0, 1'b0, 32'h4,   32'h0, ERR ? 32'h11111111 : 32'hCAFEF00D, 1'b0);
    xact(0, 1'b1, 32'h13,  32'hAAAA5555, 32'h0, ERR);
    v10 = ERR ? 32'hDEADBEEF : 32'hAAAA5555;
    xact(0, 1'b0, 32'h10,  32'h0, v10, 1'b0);
    xact(0, 1'b0, 32'h12,  32'h0, ERR ? 32'h0 : v10, ERR);

    // Back-to-back throughput: WAIT_CYCLES + 2 cycles between acceptances.
    issue(0, 1'b0, 32'h4, 32'h0, ERR ? 32'h11111111 : 32'hCAFEF00D, 1'b0, 1'b1);
    a0 = last_acc[0];
    issue(0, 1'b0, 32'h10, 32'h0, v10, 1'b0, 1'b1);
    check("throughput d0", last_acc[0] - a0, 32'd4);
    drain(0);

    // Backpressure: hold rsp_ready low for 5 cycles.
    rsp_ready[0] = 1'b0;
    issue(0, 1'b0, 32'h10, 32'h0, v10, 1'b0, 1'b1);
    n = 0;
    while (rsp_valid[0] !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_rsp_valid", {31'd0, rsp_valid[0]}, 32'd1);
      check("bp_req_ready", {31'd0, req_ready[0]}, 32'd0);
      check("bp_rdata", rsp_rdata[0], v10);
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", {31'd0, rsp_valid[0]}, 32'd0);
    check("bp_release_ready", {31'd0, req_ready[0]}, 32'd1);
    check("bp_release_rdata", rsp_rdata[0], v10);
    drain(0);

    // Reset in BUSY abandons the write.
    xact(0, 1'b1, 32'h20, 32'h00000055, 32'h0, 1'b0);
    issue(0, 1'b1, 32'h20, 32'h00000001, 32'h0, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("busy_rst_valid", {31'd0, rsp_valid[0]}, 32'd0);
    check("busy_rst_ready", {31'd0, req_ready[0]}, 32'd1);
    @(posedge clk); #1;
    check("busy_rst_ready2", {31'd0, req_ready[0]}, 32'd1);
    check("busy_rst_rdata", rsp_rdata[0], 32'd0);
    xact(0, 1'b0, 32'h20, 32'h0, 32'h00000055, 1'b0);

    // Zero wait states.
    xact(1, 1'b1, 32'h0,  32'h12345678, 32'h0, 1'b0);
    xact(1, 1'b0, 32'h0,  32'h0, 32'h12345678, 1'b0);
    xact(1, 1'b1, 32'hFC, 32'h0BADF00D, 32'h0, 1'b0);
    issue(1, 1'b0, 32'hFC, 32'h0, 32'h0BADF00D, 1'b0, 1'b1);
    a0 = last_acc[1];
    issue(1, 1'b0, 32'h0, 32'h0, 32'h12345678, 1'b0, 1'b1);
    check("throughput d1", last_acc[1] - a0, 32'd2);
    drain(1);

    drain(0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
